fir_mac_sequencer: RTL and testbench
====================================

# fir_mac_sequencer

Time-multiplexed controller for the FIR filter. It sequences one shared signed multiply-accumulate unit through all NOF_COEFF taps for each input sample, holds the sample delay line and the coefficient bank, and returns one FILTER_OUTPUT_DATA_WIDTH result per accepted sample. It sits between the sample source and the filter-output consumer, and uses valid/ready handshakes on both sides.

## Interface
Parameters:
- DATA_WIDTH, 8, sample and coefficient width (signed two's complement)
- NOF_COEFF, 12, number of taps, which is also the delay-line depth
- OUT_WIDTH, 20, output width (equals FILTER_OUTPUT_DATA_WIDTH)
- ADDR_WIDTH, $clog2(NOF_COEFF) = 4, coefficient address width

Ports:
- clk  in  1  clock; every register updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- coef_we  in  1  coefficient write strobe
- coef_addr  in  ADDR_WIDTH  tap index k
- coef_wdata  in  DATA_WIDTH  coefficient c[k], signed
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- in_data  in  DATA_WIDTH  sample x[n], signed
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_data  out  OUT_WIDTH  y[n], signed
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states and transitions:
  - IDLE: in_ready=1. When in_valid&&in_ready, write x[n] to line[wr_ptr], set k=0 and acc=0, and go to MAC.
  - MAC: each cycle, acc += c[k]*line[(wr_ptr-k) mod NOF_COEFF] and k++. After k=NOF_COEFF-1, go to OUT.
  - OUT: out_valid=1 and out_data=acc. When out_ready, advance wr_ptr (wrapping NOF_COEFF-1 to 0) and go to IDLE.
- Result: y[n] = sum over k=0..NOF_COEFF-1 of c[k]*x[n-k]. Samples not yet received count as 0.
- Arithmetic: 8x8 signed product into 16 bits, sign-extended to OUT_WIDTH, two's-complement accumulate, no saturation.
  - With the default parameters overflow is impossible: the worst case is 12*16384 = 196608 < 2^19.
- Coefficient writes:
  - Take effect only in IDLE.
  - coef_we in MAC or OUT is dropped.
  - coef_addr >= NOF_COEFF is ignored.
- in_valid outside IDLE is ignored; no sample is lost, because the source must hold the sample until the handshake.
- Simultaneous in_valid and coef_we in IDLE: both happen. The sample enters MAC, and the new coefficient applies to that computation.
- Reset values (asynchronous, any state):
  - state=IDLE; wr_ptr=0; k=0; acc=0.
  - All line[] and c[] entries = 0.
  - out_valid=0; out_data=0; busy=0.
  - in_ready is forced to 0 while rst is high.
- Reset mid-operation aborts the current computation, and no result is emitted.

## Timing
- Accepting edge E0. MAC accumulates on edges E1..E12. out_valid rises after E12, i.e. 12 cycles of latency from acceptance.
- OUT holds out_valid and out_data stable until the edge where out_ready=1. out_valid falls after that edge.
- in_ready re-asserts the cycle after the output handshake.
- With in_valid=1 and out_ready=1 held continuously, the block accepts one sample every 14 cycles.
- in_ready, out_valid and busy are decoded from the registered state with no input-to-output combinational path. The exception is in_ready's gating by rst.
- The delay-line write (E0) and the first tap read (E1) must not conflict: tap 0 reads the newly written sample.

## Test plan
- Impulse: load c[k]=k+1, then feed 1 followed by eleven 0 samples, with out_ready=1. Outputs must be 1,2,...,12, and the 13th sample (0) must give 0.
- Extremes:
  - All c=-128 and 12 samples of -128: the 12th output is 196608.
  - All c=127 with samples -128: the 12th output is -195072.
  - No wrap may occur in either case.
- Backpressure: hold out_ready=0 for 5 cycles in OUT. out_data stays constant, in_ready=0, and in_valid is not consumed. Release gives exactly one handshake, then in_ready=1 on the next cycle.
- Coefficient protection:
  - With c[0]=2, write c[0]=5 during MAC: the result uses 2.
  - A write to addr 12 or 15 in IDLE leaves c[] unchanged.
  - A write in IDLE concurrent with sample acceptance is used by that sample.
- Reset mid-MAC: assert rst at MAC cycle 6. out_valid=0, busy=0, and in_ready=0 during rst. After release, feed an impulse with c reloaded to 3: output is 3, with no stale history.
- Throughput and wrap: with continuous valid/ready, send 30 random samples. Acceptances occur exactly every 14 cycles and wr_ptr wraps twice. All outputs match a golden model.

Source files
------------

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer
// Time-multiplexed FIR controller: one shared signed multiply-accumulate is
// stepped through every tap for each accepted sample. Holds the circular
// sample delay line and the coefficient bank, and hands one result per sample
// to the consumer over a valid/ready handshake.
module fir_mac_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int NOF_COEFF  = 12,
    parameter int OUT_WIDTH  = 20,
    parameter int ADDR_WIDTH = $clog2(NOF_COEFF)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  coef_we,
    input  logic [ADDR_WIDTH-1:0] coef_addr,
    input  logic [DATA_WIDTH-1:0] coef_wdata,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Index of the last tap, and the depth folded into ADDR_WIDTH bits so the
    // circular subtraction wraps correctly (it folds to 0 for power-of-two depths).
    localparam logic [ADDR_WIDTH-1:0] LAST_TAP    = ADDR_WIDTH'(NOF_COEFF - 1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_TRUNC = ADDR_WIDTH'(NOF_COEFF);

    state_t                         state_reg;
    logic [ADDR_WIDTH-1:0]          wr_ptr_reg;
    logic [ADDR_WIDTH-1:0]          k_reg;
    logic signed [OUT_WIDTH-1:0]    acc_reg;
    logic signed [OUT_WIDTH-1:0]    out_data_reg;
    logic                           in_ready_reg;
    logic                           out_valid_reg;
    logic                           busy_reg;

    logic signed [DATA_WIDTH-1:0]   coef_reg [NOF_COEFF];
    logic signed [DATA_WIDTH-1:0]   line_reg [NOF_COEFF];

    logic                           accept;
    logic                           coef_wr;
    logic [ADDR_WIDTH-1:0]          tap_idx;
    logic signed [2*DATA_WIDTH-1:0] product;
    logic signed [OUT_WIDTH-1:0]    product_ext;
    logic signed [OUT_WIDTH-1:0]    acc_next;

    // A sample is taken only in IDLE; coefficient writes are honoured only in
    // IDLE and only for addresses inside the tap range.
    assign accept  = (state_reg == IDLE) && in_valid;
    assign coef_wr = (state_reg == IDLE) && coef_we && (coef_addr <= LAST_TAP);

    // Tap k reads the sample k positions older than the newest one, which
    // sits at wr_ptr; the newest sample is written on the accepting edge and
    // read by tap 0 on the following edge, so there is no read/write clash.
    assign tap_idx = (wr_ptr_reg >= k_reg) ? (wr_ptr_reg - k_reg)
                                           : (wr_ptr_reg - k_reg + DEPTH_TRUNC);

    // Full-precision signed product, sign-extended into the accumulator width.
    assign product     = coef_reg[k_reg] * line_reg[tap_idx];
    assign product_ext = {{(OUT_WIDTH - 2*DATA_WIDTH){product[2*DATA_WIDTH-1]}}, product};
    assign acc_next    = acc_reg + product_ext;

    // Status outputs come straight from registers; in_ready is also held low
    // while reset is asserted.
    assign in_ready  = in_ready_reg & ~rst;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign busy      = busy_reg;

    // Coefficient bank: cleared on reset, written from the host while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NOF_COEFF; i++) begin
                coef_reg[i] <= '0;
            end
        end else if (coef_wr) begin
            coef_reg[coef_addr] <= coef_wdata;
        end
    end

    // Delay line: cleared on reset so unreceived history counts as zero;
    // the accepted sample lands at the current write pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NOF_COEFF; i++) begin
                line_reg[i] <= '0;
            end
        end else if (accept) begin
            line_reg[wr_ptr_reg] <= in_data;
        end
    end

    // Sequencer FSM: accept sample, run one MAC per tap, present the result
    // until the consumer takes it, then advance the delay-line pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            wr_ptr_reg    <= '0;
            k_reg         <= '0;
            acc_reg       <= '0;
            out_data_reg  <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        state_reg    <= MAC;
                        k_reg        <= '0;
                        acc_reg      <= '0;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                    end
                end
                MAC: begin
                    acc_reg <= acc_next;
                    if (k_reg == LAST_TAP) begin
                        state_reg     <= OUT;
                        k_reg         <= '0;
                        out_data_reg  <= acc_next;
                        out_valid_reg <= 1'b1;
                    end else begin
                        k_reg <= k_reg + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        wr_ptr_reg    <= (wr_ptr_reg == LAST_TAP) ? '0 : wr_ptr_reg + 1'b1;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        busy_reg      <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer
// Directed bench for the FIR MAC sequencer. A reference model (shift-register
// history plus coefficient copy) computes each expected result when a sample
// is accepted and queues it; results are popped and checked on output.
module tb_fir_mac_sequencer;

    localparam int DW = 8;
    localparam int NC = 12;
    localparam int OW = 20;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          coef_we = 1'b0;
    logic [AW-1:0] coef_addr = '0;
    logic [DW-1:0] coef_wdata = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [OW-1:0] out_data;
    logic          busy;

    fir_mac_sequencer #(
        .DATA_WIDTH(DW),
        .NOF_COEFF (NC),
        .OUT_WIDTH (OW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_wdata(coef_wdata),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int m_coef [NC];
    int m_hist [NC];
    int sb [$];
    int acc_cyc  = 0;
    int last_out = 0;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NC; i++) begin
            m_coef[i] = 0;
            m_hist[i] = 0;
        end
        sb.delete();
    endtask

    // Called at a negedge; one coefficient write on the following edge.
    task automatic write_coef(input int addr, input int data, input bit apply);
        coef_we    = 1'b1;
        coef_addr  = AW'(addr);
        coef_wdata = DW'(data);
        @(negedge clk);
        coef_we = 1'b0;
        if (apply && addr < NC) m_coef[addr] = data;
        $display("coef write addr=%0d data=%0d applied=%0d", addr, data, apply);
    endtask

    // Offer a sample and wait (bounded) for the accepting edge.
    task automatic push(input int x, input bit chk_tp);
        int n;
        int y;
        n = 0;
        in_valid = 1'b1;
        in_data  = DW'(x);
        while (!in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("accept", int'(in_ready), 1);
        if (chk_tp) check("interval", cyc - acc_cyc, 14);
        acc_cyc = cyc;
        for (int i = NC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = x;
        y = 0;
        for (int i = 0; i < NC; i++) y += m_coef[i] * m_hist[i];
        sb.push_back(y);
        @(negedge clk);
        in_valid = 1'b0;
        check("busy_in_mac", int'(busy), 1);
        $display("sample in x=%0d expect=%0d", x, y);
    endtask

    // Wait (bounded) for a result, optionally stall the consumer, then take it.
    task automatic pop(input int hold, input bit chk_lat);
        int n;
        int first;
        int exp;
        n = 0;
        while (!out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_rise", int'(out_valid), 1);
        if (chk_lat) check("latency", cyc - acc_cyc, 13);
        first = int'($signed(out_data));
        out_ready = (hold == 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", int'(out_valid), 1);
            check("hold_data", int'($signed(out_data)), first);
            check("hold_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        check("sb_nonempty", int'(sb.size() > 0), 1);
        exp = (sb.size() > 0) ? sb.pop_front() : 0;
        last_out = int'($signed(out_data));
        check("result", last_out, exp);
        $display("result out=%0d expect=%0d", last_out, exp);
        @(negedge clk);
        check("post_hs_valid", int'(out_valid), 0);
        check("post_hs_in_ready", int'(in_ready), 1);
    endtask

    initial begin
        model_clear();

        // Reset state
        #1;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_out_data", int'(out_data), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", int'(in_ready), 1);
        check("idle_busy", int'(busy), 0);

        // Impulse response with c[k] = k+1
        for (int k = 0; k < NC; k++) write_coef(k, k + 1, 1'b1);
        push(1, 1'b0);
        pop(0, 1'b1);
        check("impulse_first", last_out, 1);
        for (int i = 1; i <= 12; i++) begin
            push(0, 1'b0);
            pop(0, 1'b1);
            if (i == 11) check("impulse_12th", last_out, 12);
        end
        check("impulse_13th", last_out, 0);

        // Extremes: largest positive and largest negative sums
        for (int k = 0; k < NC; k++) write_coef(k, -128, 1'b1);
        for (int i = 0; i < NC; i++) begin
            push(-128, 1'b0);
            pop(0, 1'b0);
        end
        check("extreme_pos", last_out, 196608);
        for (int k = 0; k < NC; k++) write_coef(k, 127, 1'b1);
        for (int i = 0; i < NC; i++) begin
            push(-128, 1'b0);
            pop(0, 1'b0);
        end
        check("extreme_neg", last_out, -195072);

        // Backpressure: 5 stalled cycles with a pending sample offered
        for (int k = 0; k < NC; k++) write_coef(k, k - 5, 1'b1);
        push(5, 1'b0);
        in_valid = 1'b1;
        in_data  = DW'(7);
        pop(5, 1'b1);
        push(7, 1'b0);
        pop(0, 1'b1);

        // Coefficient protection
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        write_coef(0, 2, 1'b1);
        push(1, 1'b0);
        @(negedge clk);
        write_coef(0, 5, 1'b0);
        pop(0, 1'b0);
        check("mac_write_dropped", last_out, 2);
        write_coef(12, 9, 1'b1);
        write_coef(15, 9, 1'b1);
        push(1, 1'b0);
        pop(0, 1'b0);
        check("oob_write_ignored", last_out, 2);
        coef_we    = 1'b1;
        coef_addr  = AW'(0);
        coef_wdata = DW'(4);
        m_coef[0]  = 4;
        push(3, 1'b0);
        coef_we = 1'b0;
        pop(0, 1'b0);
        check("concurrent_write", last_out, 12);

        // Reset during MAC cycle 6
        push(9, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_in_ready", int'(in_ready), 0);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_busy", int'(busy), 0);
        @(negedge clk);
        check("midrst_hold_valid", int'(out_valid), 0);
        rst = 1'b0;
        model_clear();
        repeat (16) @(negedge clk);
        check("no_stale_result", int'(out_valid), 0);
        for (int k = 0; k < NC; k++) write_coef(k, 3, 1'b1);
        push(1, 1'b0);
        pop(0, 1'b1);
        check("post_rst_impulse", last_out, 3);

        // Throughput and pointer wrap with random data and coefficients
        for (int k = 0; k < NC; k++) write_coef(k, $urandom_range(255) - 128, 1'b1);
        for (int i = 0; i < 30; i++) begin
            push(int'($urandom_range(255)) - 128, i > 0);
            in_valid = 1'b1;
            pop(0, 1'b1);
        end
        in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
